alu_ctrl_arb: RTL and testbench

Two-requester controller that shares one ALU instance (16-bit AND/OR/XOR/NAND/NOR/ADD/SUB/INC/MUL/DIV/EQ/GE/LE, 4-bit opcode) between two clients.
- Arbitrates requests round-robin with valid/ready handshakes.
- Registers and holds operands on the ALU inputs.
- Stretches MUL/DIV to a configurable multi-cycle latency.
- Returns the captured result to the owning requester through a response handshake.

---
 rtl/alu_pkg.sv | 33 +++
 rtl/rr_arb2.sv | 23 ++
 rtl/alu_ctrl_arb.sv | 193 +++++++++++++++++++
 tb/tb_alu_ctrl_arb.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcode encodings, default datapath width and FSM
//               state type for the shared-ALU controller.
// Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int WIDTH_DEF = 16;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_NAND = 4'b0011;
    localparam logic [3:0] OP_NOR  = 4'b0100;
    localparam logic [3:0] OP_ADD  = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_INC  = 4'b0111;
    localparam logic [3:0] OP_MUL  = 4'b1000;
    localparam logic [3:0] OP_DIV  = 4'b1001;
    localparam logic [3:0] OP_EQ   = 4'b1010;
    localparam logic [3:0] OP_GE   = 4'b1011;
    localparam logic [3:0] OP_LE   = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arb2
// Description : Two-way round-robin arbiter. pointer names the requester that
//               won last; the other requester has priority on contention.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 (
    input  logic [1:0] valid,
    input  logic       pointer,
    input  logic       enable,
    output logic [1:0] grant
);

    // One-hot grant: a lone requester always wins, ties go to the non-pointer side
    always_comb begin
        grant    = 2'b00;
        grant[0] = enable && valid[0] && (pointer || !valid[1]);
        grant[1] = enable && valid[1] && (!pointer || !valid[0]);
    end

endmodule
`default_nettype wire

// File: rtl/alu_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module      : alu_ctrl_arb
// Description : Shares one external ALU between two requesters. Round-robin
//               accept, registered operands held on the ALU inputs, MUL/DIV
//               stretched to MULDIV_LAT cycles, result returned through a
//               response handshake to the owning requester.
//               Optional macro ALU_CTRL_ERR_EN: DIV-by-zero and illegal
//               opcode (1101..1111) detection with an error flag.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_arb
    import alu_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter int MULDIV_LAT = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [3:0]       req0_op,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [3:0]       req1_op,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             resp0_valid,
    input  logic             resp0_ready,
    output logic [WIDTH-1:0] resp0_result,
    output logic             resp0_err,
    output logic             resp1_valid,
    input  logic             resp1_ready,
    output logic [WIDTH-1:0] resp1_result,
    output logic             resp1_err,
    output logic [3:0]       alu_op,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_result,
    output logic             busy
);

    // Counter must hold MULDIV_LAT; at least one bit wide
    localparam int CW = (MULDIV_LAT < 2) ? 1 : $clog2(MULDIV_LAT + 1);
    localparam logic [CW-1:0] C_CNT_ONE = CW'(1);
    localparam logic [CW-1:0] C_CNT_MD  = CW'(MULDIV_LAT);

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_ptr;
    logic             r_owner;
    logic [CW-1:0]    r_cnt;
    logic [3:0]       r_alu_op;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [WIDTH-1:0] r_result;
    logic             r_err;

    logic [1:0]       w_grant;
    logic             w_arb_en;
    logic             w_accept;
    logic             w_sel_owner;
    logic [3:0]       w_sel_op;
    logic [WIDTH-1:0] w_sel_a;
    logic [WIDTH-1:0] w_sel_b;
    logic [3:0]       w_fwd_op;
    logic [CW-1:0]    w_cnt_init;
    logic             w_resp_hs;
    logic             w_cnt_last;
    logic [WIDTH-1:0] w_cap_result;
    logic             w_cap_err;

    rr_arb2 u_arb (
        .valid   ({req1_valid, req0_valid}),
        .pointer (r_ptr),
        .enable  (w_arb_en),
        .grant   (w_grant)
    );

    assign w_accept    = |w_grant;
    assign w_sel_owner = w_grant[1];
    assign w_sel_op    = w_sel_owner ? req1_op : req0_op;
    assign w_sel_a     = w_sel_owner ? req1_a  : req0_a;
    assign w_sel_b     = w_sel_owner ? req1_b  : req0_b;
    assign w_cnt_last  = (r_cnt == C_CNT_ONE);
    assign w_resp_hs   = (r_state == ST_RESP) && (r_owner ? resp1_ready : resp0_ready);

`ifdef ALU_CTRL_ERR_EN
    logic r_illegal;
    logic w_sel_illegal;
    logic w_div_zero;

    // Illegal opcodes never reach the ALU and complete in a single cycle
    assign w_sel_illegal = (w_sel_op > OP_LE);
    assign w_fwd_op      = w_sel_illegal ? OP_AND : w_sel_op;
    assign w_cnt_init    = (!w_sel_illegal && (w_sel_op == OP_MUL || w_sel_op == OP_DIV))
                           ? C_CNT_MD : C_CNT_ONE;
    assign w_div_zero    = !r_illegal && (r_alu_op == OP_DIV) && (r_alu_b == '0);
    assign w_cap_result  = r_illegal ? '0 : (w_div_zero ? '1 : alu_result);
    assign w_cap_err     = r_illegal || w_div_zero;

    // Remember whether the accepted opcode was outside the ALU encoding
    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_illegal <= w_sel_illegal;
        end
    end
`else
    assign w_fwd_op     = w_sel_op;
    assign w_cnt_init   = (w_sel_op == OP_MUL || w_sel_op == OP_DIV) ? C_CNT_MD : C_CNT_ONE;
    assign w_cap_result = alu_result;
    assign w_cap_err    = 1'b0;
`endif

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next-state: accept -> execute for cnt cycles -> hold response
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (w_accept)   w_state_nxt = ST_EXEC;
            ST_EXEC: if (w_cnt_last) w_state_nxt = ST_RESP;
            ST_RESP: if (w_resp_hs)  w_state_nxt = ST_IDLE;
            default:                 w_state_nxt = ST_IDLE;
        endcase
    end

    // FSM outputs: handshakes and busy decoded from state and owner
    always_comb begin
        w_arb_en    = (r_state == ST_IDLE);
        req0_ready  = w_grant[0];
        req1_ready  = w_grant[1];
        resp0_valid = (r_state == ST_RESP) && !r_owner;
        resp1_valid = (r_state == ST_RESP) &&  r_owner;
        busy        = (r_state != ST_IDLE);
    end

    // Datapath: operand capture on accept, latency count and result capture
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= 1'b1;
            r_owner  <= 1'b0;
            r_cnt    <= '0;
            r_alu_op <= '0;
            r_alu_a  <= '0;
            r_alu_b  <= '0;
            r_result <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_op <= w_fwd_op;
                        r_alu_a  <= w_sel_a;
                        r_alu_b  <= w_sel_b;
                        r_owner  <= w_sel_owner;
                        r_ptr    <= w_sel_owner;
                        r_cnt    <= w_cnt_init;
                    end
                end
                ST_EXEC: begin
                    r_cnt <= r_cnt - C_CNT_ONE;
                    if (w_cnt_last) begin
                        r_result <= w_cap_result;
                        r_err    <= w_cap_err;
                    end
                end
                default: ;
            endcase
        end
    end

    assign alu_op       = r_alu_op;
    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign resp0_result = r_result;
    assign resp1_result = r_result;
    assign resp0_err    = r_err;
    assign resp1_err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_alu_ctrl_arb.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_ctrl_arb
// Description : Directed self-checking bench for alu_ctrl_arb with a
//               behavioural ALU and a response scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_arb;

    localparam int W   = 16;
    localparam int LAT = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [3:0]   req0_op, req1_op, alu_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         resp0_valid, resp0_ready, resp0_err;
    logic         resp1_valid, resp1_ready, resp1_err;
    logic [W-1:0] resp0_result, resp1_result;
    logic [W-1:0] alu_a, alu_b, alu_result;
    logic         busy;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic         owner;
        logic [W-1:0] res;
        logic         err;
    } exp_t;

    exp_t sb[$];
    bit   grant_q[$];
    exp_t m_e;

    always #5 clk = ~clk;

    alu_ctrl_arb #(.WIDTH(W), .MULDIV_LAT(LAT)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp0_result(resp0_result), .resp0_err(resp0_err),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp1_result(resp1_result), .resp1_err(resp1_err),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .busy(busy)
    );

    // Behavioural ALU sitting outside the controller
    function automatic logic [W-1:0] alu_f(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            4'b0000: return a & b;
            4'b0001: return a | b;
            4'b0010: return a ^ b;
            4'b0011: return ~(a & b);
            4'b0100: return ~(a | b);
            4'b0101: return a + b;
            4'b0110: return a - b;
            4'b0111: return a + 1'b1;
            4'b1000: return a * b;
            4'b1001: return (b == '0) ? '1 : a / b;
            4'b1010: return {{(W-1){1'b0}}, a == b};
            4'b1011: return {{(W-1){1'b0}}, a >= b};
            4'b1100: return {{(W-1){1'b0}}, a <= b};
            default: return '0;
        endcase
    endfunction

    assign alu_result = alu_f(alu_op, alu_a, alu_b);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 30; i++) begin
            if (!busy) break;
            cyc();
        end
        chk("idle_timeout", busy, 0);
    endtask

    // Issue one request and run it through to the response handshake
    task automatic do_op(input bit who, input logic [3:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic [W-1:0] er, input logic ee);
        int n;
        sb.push_back('{who, er, ee});
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        if (who) begin
            req1_op = op; req1_a = a; req1_b = b; req1_valid = 1'b1;
        end else begin
            req0_op = op; req0_a = a; req0_b = b; req0_valid = 1'b1;
        end
        #1;
        n = 0;
        while (!(who ? req1_ready : req0_ready) && n < 10) begin
            cyc();
            n++;
        end
        chk("grant_timeout", who ? req1_ready : req0_ready, 1);
        cyc();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
    endtask

    // Monitor: protocol invariants, accept order and scoreboard compare
    always @(negedge clk) begin
        if (!rst) begin
            chk("both_ready", req0_ready & req1_ready, 0);
            chk("both_resp_valid", resp0_valid & resp1_valid, 0);
            if (req0_valid && req0_ready) grant_q.push_back(1'b0);
            if (req1_valid && req1_ready) grant_q.push_back(1'b1);
            if ((resp0_valid && resp0_ready) || (resp1_valid && resp1_ready)) begin
                if (sb.size() == 0) begin
                    chk("unexpected_resp", 32'(sb.size()), 1);
                end else begin
                    m_e = sb.pop_front();
                    chk("resp_owner", resp1_valid, m_e.owner);
                    chk("resp_result", resp1_valid ? resp1_result : resp0_result, m_e.res);
                    chk("resp_err", resp1_valid ? resp1_err : resp0_err, m_e.err);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req0_valid = 0; req1_valid = 0;
        req0_op = 0; req0_a = 0; req0_b = 0;
        req1_op = 0; req1_a = 0; req1_b = 0;
        resp0_ready = 1'b1; resp1_ready = 1'b1;
        cyc(); cyc();
        rst = 1'b0;

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_alu_op", alu_op, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_resp_valid", {resp1_valid, resp0_valid}, 0);
        chk("rst_ready", {req1_ready, req0_ready}, 0);

        // Single ADD on requester 0
        sb.push_back('{1'b0, 16'h0007, 1'b0});
        req0_op = 4'b0101; req0_a = 16'h0003; req0_b = 16'h0004; req0_valid = 1'b1;
        #1;
        chk("add_req0_ready", req0_ready, 1);
        chk("add_req1_ready", req1_ready, 0);
        cyc();
        req0_valid = 1'b0;
        chk("add_busy", busy, 1);
        chk("add_alu_op", alu_op, 4'b0101);
        chk("add_alu_a", alu_a, 16'h0003);
        chk("add_early_resp", resp0_valid, 0);
        cyc();
        chk("add_resp_valid", resp0_valid, 1);
        chk("add_result", resp0_result, 16'h0007);
        chk("add_resp1_quiet", resp1_valid, 0);
        cyc();
        chk("add_back_idle", busy, 0);

        // MUL on requester 1: operands held for LAT cycles, result at E+LAT
        sb.push_back('{1'b1, 16'h0200, 1'b0});
        req1_op = 4'b1000; req1_a = 16'h0010; req1_b = 16'h0020; req1_valid = 1'b1;
        #1;
        chk("mul_req1_ready", req1_ready, 1);
        cyc();
        req1_valid = 1'b0;
        for (int i = 0; i < LAT; i++) begin
            chk("mul_hold_op", alu_op, 4'b1000);
            chk("mul_hold_a", alu_a, 16'h0010);
            chk("mul_hold_b", alu_b, 16'h0020);
            chk("mul_early_resp", resp1_valid, 0);
            cyc();
        end
        chk("mul_resp_valid", resp1_valid, 1);
        chk("mul_result", resp1_result, 16'h0200);
        wait_idle();

        // Continuous contention: strict alternation starting with requester 0
        grant_q.delete();
        for (int i = 0; i < 2; i++) begin
            sb.push_back('{1'b0, 16'h0FF0, 1'b0});
            sb.push_back('{1'b1, 16'hFFFF, 1'b0});
        end
        req0_op = 4'b0010; req0_a = 16'h00FF; req0_b = 16'h0F0F;
        req1_op = 4'b0110; req1_a = 16'h0000; req1_b = 16'h0001;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        for (int i = 0; i < 40; i++) begin
            if (!(req0_ready || req1_ready)) chk("contend_busy", busy, 1);
            cyc();
            if (grant_q.size() >= 4) break;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("contend_accepts", 32'(grant_q.size()), 4);
        for (int i = 0; i < grant_q.size(); i++) chk("contend_order", grant_q[i], i % 2);
        wait_idle();

        // Stalled response: result stable, other requester locked out
        sb.push_back('{1'b0, 16'hF000, 1'b0});
        sb.push_back('{1'b1, 16'h1235, 1'b0});
        resp0_ready = 1'b0;
        req0_op = 4'b0000; req0_a = 16'hF0F0; req0_b = 16'hFF00;
        req1_op = 4'b0001; req1_a = 16'h1234; req1_b = 16'h0001;
        req0_valid = 1'b1; req1_valid = 1'b1;
        #1;
        chk("stall_req0_ready", req0_ready, 1);
        cyc();
        req0_valid = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", resp0_valid, 1);
            chk("stall_result", resp0_result, 16'hF000);
            chk("stall_req1_blocked", req1_ready, 0);
            cyc();
        end
        resp0_ready = 1'b1;
        #1;
        chk("stall_hs_req1_blocked", req1_ready, 0);
        cyc();
        chk("stall_after_hs_valid", resp0_valid, 0);
        chk("stall_req1_granted", req1_ready, 1);
        cyc();
        req1_valid = 1'b0;
        wait_idle();

        // Miscellaneous ops, boundaries and error behaviour
        do_op(1'b0, 4'b1010, 16'h0005, 16'h0005, 16'h0001, 1'b0);
        do_op(1'b1, 4'b1011, 16'h0003, 16'h0007, 16'h0000, 1'b0);
        do_op(1'b0, 4'b0111, 16'hFFFF, 16'h0000, 16'h0000, 1'b0);
        do_op(1'b1, 4'b1001, 16'd100, 16'd7, 16'd14, 1'b0);
`ifdef ALU_CTRL_ERR_EN
        do_op(1'b0, 4'b1001, 16'h1234, 16'h0000, 16'hFFFF, 1'b1);
        sb.push_back('{1'b1, 16'h0000, 1'b1});
`else
        do_op(1'b0, 4'b1001, 16'h1234, 16'h0000, 16'hFFFF, 1'b0);
        sb.push_back('{1'b1, 16'h0000, 1'b0});
`endif
        req1_op = 4'b1110; req1_a = 16'h0005; req1_b = 16'h0005; req1_valid = 1'b1;
        #1;
        chk("illegal_ready", req1_ready, 1);
        cyc();
        req1_valid = 1'b0;
`ifdef ALU_CTRL_ERR_EN
        chk("illegal_alu_op", alu_op, 4'b0000);
`else
        chk("illegal_alu_op", alu_op, 4'b1110);
`endif
        cyc();
        chk("illegal_resp_valid", resp1_valid, 1);
        wait_idle();

        // Reset in the middle of a MUL abandons it
        req0_op = 4'b1000; req0_a = 16'h0003; req0_b = 16'h0003; req0_valid = 1'b1;
        #1;
        cyc();
        req0_valid = 1'b0;
        chk("rstmid_busy", busy, 1);
        cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("rstmid_idle", busy, 0);
        chk("rstmid_alu_op", alu_op, 0);
        chk("rstmid_alu_a", alu_a, 0);
        for (int i = 0; i < LAT + 2; i++) begin
            chk("rstmid_no_resp", {resp1_valid, resp0_valid}, 0);
            cyc();
        end
        do_op(1'b1, 4'b0101, 16'hFFFF, 16'h0002, 16'h0001, 1'b0);

        chk("sb_drained", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
